// File: rtl/txhex_pkg.sv
// Shared ASCII constants, line-terminator modes and formatter state encoding
// for the hex-printing UART queue.
package txhex_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_A  = 8'h61;
    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;

    localparam int EOL_NONE = 0;
    localparam int EOL_LF   = 1;
    localparam int EOL_CRLF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_HEX,
        ST_CR,
        ST_LF
    } fmt_state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (ASCII_A + {4'd0, n} - 8'd10);
    endfunction

endpackage

// File: rtl/txuart.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each held
// CLOCKS_PER_BAUD cycles; the line idles high.
module txuart #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_uart_tx
);

    localparam int BW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    logic          last_cycle;

    assign last_cycle = busy_q && (bit_q == 4'd9) && (baud_q == '0);

    // Ready is advertised during the final stop-bit cycle so a registered
    // write from the caller lands after exactly one idle-high cycle.
    assign o_busy    = busy_q && !last_cycle;
    assign o_uart_tx = tx_q;

    always_comb begin
        busy_d = busy_q;
        tx_d   = tx_q;
        baud_d = baud_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        if (!busy_q) begin
            if (i_wr) begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
                sh_d   = {1'b1, i_data};
                bit_d  = 4'd0;
                baud_d = BAUD_LAST;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - BW'(1);
        end else if (bit_q == 4'd9) begin
            busy_d = 1'b0;
        end else begin
            tx_d   = sh_q[0];
            sh_d   = {1'b1, sh_q[8:1]};
            bit_d  = bit_q + 4'd1;
            baud_d = BAUD_LAST;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            baud_q <= '0;
            bit_q  <= 4'd0;
            sh_q   <= '1;
        end else begin
            busy_q <= busy_d;
            tx_q   <= tx_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
        end
    end

endmodule

// File: rtl/txhex_queue.sv
// Word queue feeding a formatter that prints each word as lowercase hex text,
// with optional "0x" prefix and line terminator, over a UART line.
module txhex_queue
    import txhex_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int DW              = 32,
    parameter int LGFIFO          = 2,
    parameter int PREFIX          = 1,
    parameter int EOL             = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic          o_drop,
    output logic          o_uart_tx
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam int NIB   = DW / 4;
    localparam int NW    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [LGFIFO:0] FULL_CNT = (LGFIFO + 1)'(DEPTH);
    localparam logic [NW-1:0]   NIB_LAST = NW'(NIB - 1);

    logic [DW-1:0]     fifo_mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]   count_q, count_d;
    fmt_state_t        state_q, state_d;
    logic [DW-1:0]     word_q, word_d;
    logic [NW-1:0]     nib_q, nib_d;
    logic              wr_q, wr_d;
    logic [7:0]        chr_q, chr_d;

    logic       full, push, pop, issue, uart_busy;
    logic [7:0] cur_char;
    fmt_state_t next_state, after_hex;

    // A pop on the same edge never frees room for a push: fullness is judged
    // on the registered count only.
    assign full   = (count_q == FULL_CNT);
    assign push   = i_stb && !full;
    assign pop    = (state_q == ST_IDLE) && (count_q != '0);
    assign o_busy = full;
    assign o_drop = i_stb && full;
    assign issue  = (state_q != ST_IDLE) && !wr_q && !uart_busy;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + LGFIFO'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + LGFIFO'(1)) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (LGFIFO + 1)'(1);
            2'b01:   count_d = count_q - (LGFIFO + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        if (EOL == EOL_CRLF)    after_hex = ST_CR;
        else if (EOL == EOL_LF) after_hex = ST_LF;
        else                    after_hex = ST_IDLE;

        cur_char   = ASCII_0;
        next_state = ST_IDLE;
        unique case (state_q)
            ST_P0: begin
                cur_char   = ASCII_0;
                next_state = ST_P1;
            end
            ST_P1: begin
                cur_char   = ASCII_X;
                next_state = ST_HEX;
            end
            ST_HEX: begin
                cur_char   = hex_char(word_q[DW-1 -: 4]);
                next_state = (nib_q == NIB_LAST) ? after_hex : ST_HEX;
            end
            ST_CR: begin
                cur_char   = ASCII_CR;
                next_state = ST_LF;
            end
            ST_LF: begin
                cur_char   = ASCII_LF;
                next_state = ST_IDLE;
            end
            default: begin
                cur_char   = ASCII_0;
                next_state = ST_IDLE;
            end
        endcase
    end

    // The write strobe is a registered one-cycle pulse; the UART is always
    // ready on the following edge because issue waits for its ready signal.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        nib_d   = nib_q;
        wr_d    = 1'b0;
        chr_d   = chr_q;
        if (pop) begin
            word_d  = fifo_mem[rd_ptr_q];
            nib_d   = '0;
            state_d = (PREFIX != 0) ? ST_P0 : ST_HEX;
        end else if (issue) begin
            wr_d    = 1'b1;
            chr_d   = cur_char;
            state_d = next_state;
            if ((state_q == ST_HEX) && (nib_q != NIB_LAST)) begin
                word_d = word_q << 4;
                nib_d  = nib_q + NW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            word_q   <= '0;
            nib_q    <= '0;
            wr_q     <= 1'b0;
            chr_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            word_q   <= word_d;
            nib_q    <= nib_d;
            wr_q     <= wr_d;
            chr_q    <= chr_d;
        end
    end

    txuart #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_txuart (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (wr_q),
        .i_data   (chr_q),
        .o_busy   (uart_busy),
        .o_uart_tx(o_uart_tx)
    );

endmodule
